// File: rtl/cb_skew_pkg.sv
// Shared types and helpers for the clocking-block skew sampler.
package cb_skew_pkg;

  // Container wide enough for any skew value this block supports (MAX_SKEW <= 255).
  typedef logic [7:0] skew_t;

  // Saturate a raw skew field at the configured maximum.
  function automatic skew_t clamp_skew(skew_t raw, skew_t max_skew);
    return (raw > max_skew) ? max_skew : raw;
  endfunction

endpackage

// File: rtl/cb_skew_chan.sv
// One clocking-block channel: input history, skewed sample mux, change flag and
// a short drive-slot pipeline that delays drive requests by the output skew.
module cb_skew_chan
  import cb_skew_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_SKEW = 7,
  parameter int unsigned SW       = $clog2(MAX_SKEW + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             evt_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [SW-1:0]    iskew_i,
  input  logic [SW-1:0]    oskew_i,
  input  logic             drv_we_i,
  input  logic [WIDTH-1:0] drv_d_i,
  output logic [WIDTH-1:0] cb_o,
  output logic             chg_o,
  output logic [WIDTH-1:0] drv_o
);

  // One drive slot: pending value plus its valid flag.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } slot_t;

  localparam skew_t MaxSkewT = skew_t'(MAX_SKEW);

  // h_q[k-1] holds d_i as sampled k posedges ago.
  logic [WIDTH-1:0] h_q [MAX_SKEW];
  logic [WIDTH-1:0] h_d [MAX_SKEW];

  // slot_q[k-1] is the drive that lands k posedges from now.
  slot_t slot_q [MAX_SKEW];
  slot_t slot_d [MAX_SKEW];

  logic [WIDTH-1:0] cb_q, cb_d;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] drv_q, drv_d;

  skew_t            isk;
  skew_t            osk;
  logic [WIDTH-1:0] samp;

  // Clamp both skew fields to the supported range.
  always_comb begin
    isk = clamp_skew(skew_t'(iskew_i), MaxSkewT);
    osk = clamp_skew(skew_t'(oskew_i), MaxSkewT);
  end

  // History shifts every cycle regardless of the clocking event.
  always_comb begin
    h_d[0] = d_i;
    for (int unsigned k = 1; k < MAX_SKEW; k++) begin
      h_d[k] = h_q[k-1];
    end
  end

  // Sample mux: skew 0 takes the live input, otherwise the matching history tap.
  always_comb begin
    samp = d_i;
    for (int unsigned k = 1; k <= MAX_SKEW; k++) begin
      if (isk == skew_t'(k)) begin
        samp = h_q[k-1];
      end
    end
  end

  // Sampled value and change flag update only on the clocking event.
  always_comb begin
    cb_d  = cb_q;
    chg_d = 1'b0;
    if (evt_i) begin
      cb_d  = samp;
      chg_d = (samp != cb_q);
    end
  end

  // Drive pipeline: deliver slot 1, shift down, then insert the new request.
  // The insert happens after the shift so a later request for the same landing
  // edge overwrites an earlier one.
  always_comb begin
    drv_d = drv_q;
    if (slot_q[0].valid) begin
      drv_d = slot_q[0].data;
    end
    for (int unsigned k = 0; k + 1 < MAX_SKEW; k++) begin
      slot_d[k] = slot_q[k+1];
    end
    slot_d[MAX_SKEW-1] = '0;
    if (evt_i && drv_we_i) begin
      if (osk == '0) begin
        drv_d = drv_d_i;
      end else begin
        for (int unsigned k = 1; k <= MAX_SKEW; k++) begin
          if (osk == skew_t'(k)) begin
            slot_d[k-1].valid = 1'b1;
            slot_d[k-1].data  = drv_d_i;
          end
        end
      end
    end
  end

  // History and drive-slot registers; reset discards everything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < MAX_SKEW; k++) begin
        h_q[k]    <= '0;
        slot_q[k] <= '0;
      end
    end else begin
      h_q    <= h_d;
      slot_q <= slot_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cb_q  <= '0;
      chg_q <= 1'b0;
      drv_q <= '0;
    end else begin
      cb_q  <= cb_d;
      chg_q <= chg_d;
      drv_q <= drv_d;
    end
  end

  assign cb_o  = cb_q;
  assign chg_o = chg_q;
  assign drv_o = drv_q;

endmodule

// File: rtl/cb_skew_sampler.sv
// Multi-channel clocking-block engine: per-channel skewed sampling and driving
// relative to the evt strobe. Pure port slicing around one channel per lane.
module cb_skew_sampler
  import cb_skew_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MAX_SKEW = 7,
  parameter int unsigned SW       = $clog2(MAX_SKEW + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      evt,
  input  logic [CHANNELS*WIDTH-1:0] d_in,
  input  logic [CHANNELS*SW-1:0]    iskew,
  input  logic [CHANNELS*SW-1:0]    oskew,
  input  logic [CHANNELS-1:0]       drv_we,
  input  logic [CHANNELS*WIDTH-1:0] drv_d,
  output logic [CHANNELS*WIDTH-1:0] cb_q,
  output logic [CHANNELS-1:0]       chg,
  output logic [CHANNELS*WIDTH-1:0] drv_q
);

  // One independent channel per lane.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    cb_skew_chan #(
      .WIDTH    (WIDTH),
      .MAX_SKEW (MAX_SKEW),
      .SW       (SW)
    ) u_chan (
      .clk_i    (clk),
      .rst_i    (rst),
      .evt_i    (evt),
      .d_i      (d_in[c*WIDTH +: WIDTH]),
      .iskew_i  (iskew[c*SW +: SW]),
      .oskew_i  (oskew[c*SW +: SW]),
      .drv_we_i (drv_we[c]),
      .drv_d_i  (drv_d[c*WIDTH +: WIDTH]),
      .cb_o     (cb_q[c*WIDTH +: WIDTH]),
      .chg_o    (chg[c]),
      .drv_o    (drv_q[c*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_cb_skew_sampler.sv
// Bench for cb_skew_sampler: directed table, hand-written corner sequences and
// random stimulus against a cycle-log / landing-time reference model. A second
// instance with MAX_SKEW=5 (same 3-bit skew fields) exercises clamping.
module tb_cb_skew_sampler;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int SWB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic evt = 1'b0;

  logic [W-1:0]   din [CH];
  logic [SWB-1:0] isk [CH];
  logic [SWB-1:0] osk [CH];
  logic           we  [CH];
  logic [W-1:0]   dd  [CH];

  logic [CH*W-1:0]   d_in, drv_d;
  logic [CH*SWB-1:0] iskew, oskew;
  logic [CH-1:0]     drv_we;

  logic [CH*W-1:0] cb_a, drv_a, cb_b, drv_b;
  logic [CH-1:0]   chg_a, chg_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      d_in[c*W +: W]       = din[c];
      drv_d[c*W +: W]      = dd[c];
      iskew[c*SWB +: SWB]  = isk[c];
      oskew[c*SWB +: SWB]  = osk[c];
      drv_we[c]            = we[c];
    end
  end

  cb_skew_sampler #(.WIDTH(W), .CHANNELS(CH), .MAX_SKEW(7)) dut (
    .clk(clk), .rst(rst), .evt(evt), .d_in(d_in), .iskew(iskew), .oskew(oskew),
    .drv_we(drv_we), .drv_d(drv_d), .cb_q(cb_a), .chg(chg_a), .drv_q(drv_a)
  );

  cb_skew_sampler #(.WIDTH(W), .CHANNELS(CH), .MAX_SKEW(5)) dut_c (
    .clk(clk), .rst(rst), .evt(evt), .d_in(d_in), .iskew(iskew), .oskew(oskew),
    .drv_we(drv_we), .drv_d(drv_d), .cb_q(cb_b), .chg(chg_b), .drv_q(drv_b)
  );

  // ---------------- reference model ----------------
  // dlog[c][j%16] = d_in seen at edge j since reset; pending drives are kept by
  // absolute landing edge, later writes to the same edge simply overwrite.
  int          max_sk [2] = '{7, 5};
  int          n_edge;
  logic [W-1:0] dlog  [CH][16];
  logic [W-1:0] m_cb  [2][CH];
  logic         m_chg [2][CH];
  logic [W-1:0] m_drv [2][CH];
  logic         pv    [2][CH][16];
  logic [W-1:0] pd    [2][CH][16];

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    n_edge = 0;
    for (int c = 0; c < CH; c++) begin
      for (int j = 0; j < 16; j++) dlog[c][j] = '0;
      for (int m = 0; m < 2; m++) begin
        m_cb[m][c] = '0; m_chg[m][c] = 1'b0; m_drv[m][c] = '0;
        for (int j = 0; j < 16; j++) begin pv[m][c][j] = 1'b0; pd[m][c][j] = '0; end
      end
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < CH; c++) begin
        int ki, ko;
        logic [W-1:0] v;
        ki = min2(int'(isk[c]), max_sk[m]);
        ko = min2(int'(osk[c]), max_sk[m]);
        if (evt) begin
          if (ki == 0) v = din[c];
          else if (n_edge < ki) v = '0;
          else v = dlog[c][(n_edge - ki) % 16];
          m_chg[m][c] = (v != m_cb[m][c]);
          m_cb[m][c]  = v;
        end else begin
          m_chg[m][c] = 1'b0;
        end
        if (evt && we[c]) begin
          pv[m][c][(n_edge + ko) % 16] = 1'b1;
          pd[m][c][(n_edge + ko) % 16] = dd[c];
        end
        if (pv[m][c][n_edge % 16]) begin
          m_drv[m][c] = pd[m][c][n_edge % 16];
          pv[m][c][n_edge % 16] = 1'b0;
        end
      end
    end
    for (int c = 0; c < CH; c++) dlog[c][n_edge % 16] = din[c];
    n_edge++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dut_cb(int m, int c);
    return (m == 0) ? cb_a[c*W +: W] : cb_b[c*W +: W];
  endfunction
  function automatic logic dut_chg(int m, int c);
    return (m == 0) ? chg_a[c] : chg_b[c];
  endfunction
  function automatic logic [W-1:0] dut_drv(int m, int c);
    return (m == 0) ? drv_a[c*W +: W] : drv_b[c*W +: W];
  endfunction

  task automatic compare_model();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("model dut%0d ch%0d cb", m, c), 32'(dut_cb(m, c)), 32'(m_cb[m][c]));
        check($sformatf("model dut%0d ch%0d chg", m, c), 32'(dut_chg(m, c)), 32'(m_chg[m][c]));
        check($sformatf("model dut%0d ch%0d drv", m, c), 32'(dut_drv(m, c)), 32'(m_drv[m][c]));
      end
    end
  endtask

  // One clock: model follows the DUT at the posedge, outputs compared at negedge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic clear_inputs();
    evt = 1'b0;
    for (int c = 0; c < CH; c++) begin
      din[c] = '0; isk[c] = '0; osk[c] = '0; we[c] = 1'b0; dd[c] = '0;
    end
  endtask

  // Called at a negedge; returns at a negedge with rst released.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    compare_model();
    @(negedge clk);
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         evt;
    logic [W-1:0] d0;
    logic         we1;
    logic [W-1:0] dd1;
    logic [2:0]   osk1;
    logic [W-1:0] e_cb0;
    logic         e_chg0;
    logic [W-1:0] e_drv1;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // evt, d0, we1, dd1, osk1 | cb0, chg0, drv1
    tbl[0] = '{1'b1, 8'h03, 1'b1, 8'hA5, 3'd2, 8'h03, 1'b1, 8'h00};
    tbl[1] = '{1'b0, 8'h04, 1'b0, 8'h00, 3'd0, 8'h03, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 8'h05, 1'b0, 8'h00, 3'd0, 8'h03, 1'b0, 8'hA5};
    tbl[3] = '{1'b1, 8'h09, 1'b1, 8'h5A, 3'd0, 8'h09, 1'b1, 8'h5A};
    tbl[4] = '{1'b1, 8'h09, 1'b1, 8'h11, 3'd3, 8'h09, 1'b0, 8'h5A};
    tbl[5] = '{1'b1, 8'h0A, 1'b1, 8'h22, 3'd2, 8'h0A, 1'b1, 8'h5A};
    tbl[6] = '{1'b0, 8'h0A, 1'b0, 8'h00, 3'd0, 8'h0A, 1'b0, 8'h5A};
    tbl[7] = '{1'b0, 8'h0A, 1'b0, 8'h00, 3'd0, 8'h0A, 1'b0, 8'h22};
    tbl[8] = '{1'b0, 8'h0B, 1'b1, 8'h77, 3'd0, 8'h0A, 1'b0, 8'h22};
    tbl[9] = '{1'b0, 8'h0B, 1'b0, 8'h00, 3'd0, 8'h0A, 1'b0, 8'h22};

    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset cb_q", 32'(cb_a), 32'h0);
    check("reset drv_q", 32'(drv_a), 32'h0);
    check("reset chg", 32'(chg_a), 32'h0);

    // Table: drive skews 2/0, collision 11@3 vs 22@2, ignored drv_we, no-change.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      evt = tbl[i].evt; din[0] = tbl[i].d0;
      we[1] = tbl[i].we1; dd[1] = tbl[i].dd1; osk[1] = tbl[i].osk1;
      step();
      check($sformatf("tbl%0d cb0", i), 32'(cb_a[7:0]), 32'(tbl[i].e_cb0));
      check($sformatf("tbl%0d chg0", i), 32'(chg_a[0]), 32'(tbl[i].e_chg0));
      check($sformatf("tbl%0d drv1", i), 32'(drv_a[15:8]), 32'(tbl[i].e_drv1));
    end

    // Ramp with iskew 3, evt every 5 cycles.
    do_reset();
    isk[0] = 3'd3;
    for (int i = 0; i < 25; i++) begin
      din[0] = 8'(i);
      evt = (i % 5 == 4);
      step();
      if (i % 5 == 4) begin
        check($sformatf("ramp cb0 @%0d", i), 32'(cb_a[7:0]), 32'(i - 3));
        check($sformatf("ramp chg0 @%0d", i), 32'(chg_a[0]), 32'h1);
      end
    end
    // Maximum skew 7 versus clamped-to-5 instance.
    isk[0] = 3'd7;
    for (int i = 25; i < 30; i++) begin
      din[0] = 8'(i);
      evt = (i == 29);
      step();
    end
    check("iskew 7 cb0", 32'(cb_a[7:0]), 32'd22);
    check("iskew clamp cb0", 32'(cb_b[7:0]), 32'd24);

    // Three drives at oskew 3 on consecutive evts deliver in order.
    do_reset();
    evt = 1'b1; we[1] = 1'b1; osk[1] = 3'd3;
    dd[1] = 8'h11; step();
    dd[1] = 8'h22; step();
    dd[1] = 8'h33; step();
    evt = 1'b0; we[1] = 1'b0;
    check("seq333 before", 32'(drv_a[15:8]), 32'h00);
    step(); check("seq333 first", 32'(drv_a[15:8]), 32'h11);
    step(); check("seq333 second", 32'(drv_a[15:8]), 32'h22);
    step(); check("seq333 third", 32'(drv_a[15:8]), 32'h33);

    // Reset with drives in flight.
    do_reset();
    evt = 1'b1; din[0] = 8'h5A; we[1] = 1'b1; we[3] = 1'b1;
    dd[3] = 8'hEE; osk[1] = 3'd5; dd[1] = 8'h41; step();
    osk[1] = 3'd6; dd[1] = 8'h42; we[3] = 1'b0; step();
    osk[1] = 3'd7; dd[1] = 8'h43; step();
    clear_inputs(); step();
    check("pre-reset cb0 nonzero", 32'(cb_a[7:0] != 0), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async rst cb", 32'(cb_a), 32'h0);
    check("async rst drv", 32'(drv_a), 32'h0);
    check("async rst chg", 32'(chg_a), 32'h0);
    @(negedge clk);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("post-rst drv @%0d", i), 32'(drv_a), 32'h0);
    end

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end
      evt = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < CH; c++) begin
        din[c] = 8'($urandom);
        isk[c] = 3'($urandom_range(0, 7));
        osk[c] = 3'($urandom_range(0, 7));
        we[c]  = ($urandom_range(0, 2) != 0);
        dd[c]  = 8'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
